// File: rtl/hex_state_sequencer.sv
// -----------------------------------------------------------------------------
// hex_state_sequencer
//
// Match-flow controller for a two-player fighting game.
//
// The controller walks through these phases:
//   - Idle: the 1P/2P mode can be chosen.
//   - FIGHT: the banner is shown for a fixed time.
//   - PLAYING: the match runs with a live seconds counter.
//   - Result: a result (P1 win, P2 win or draw) is held for a fixed time, or
//     until start is pressed.
//
// All outputs are registered and decoded from the next state, so they change
// on the same edge as the state itself.
//
// Timing uses two counters:
//   - A prescaler divides the clock down to one-second ticks.
//   - A seconds counter measures the FIGHT and result holds.
// Both counters restart from zero on every state change, so each timed state
// lasts a whole number of seconds measured from its entry edge.
//
// Parameters
//   CLKS_PER_SEC  clock cycles per game second
//   FIGHT_SECS    seconds the FIGHt banner is shown (>= 1)
//   RESULT_SECS   seconds a result is held before returning to idle (>= 1)
//   MAX_SECS      match time limit in seconds (1..99)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   mode_toggle    one-cycle pulse, flips 1P/2P while idle
//   start          one-cycle pulse, starts a match or skips a result hold
//   p1_dead        level, player 1 health exhausted
//   p2_dead        level, player 2 health exhausted
//   hex_state      display code: 0=1P 1=2P 2=FIGHt 3=P1 win 4=P2 win 5=Eq
//                  7=live timer
//   game_duration  elapsed match seconds, 0..MAX_SECS
//   game_active    high only while PLAYING
//   two_player     mode latched at the last match start
// -----------------------------------------------------------------------------
module hex_state_sequencer #(
    parameter int CLKS_PER_SEC = 50_000_000,
    parameter int FIGHT_SECS   = 2,
    parameter int RESULT_SECS  = 5,
    parameter int MAX_SECS     = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_toggle,
    input  logic       start,
    input  logic       p1_dead,
    input  logic       p2_dead,
    output logic [2:0] hex_state,
    output logic [6:0] game_duration,
    output logic       game_active,
    output logic       two_player
);

    localparam int PSC_W    = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam int HOLD_MAX = (FIGHT_SECS > RESULT_SECS) ? FIGHT_SECS : RESULT_SECS;
    localparam int SEC_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [PSC_W-1:0] PSC_LAST    = PSC_W'(CLKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] FIGHT_LAST  = SEC_W'(FIGHT_SECS - 1);
    localparam logic [SEC_W-1:0] RESULT_LAST = SEC_W'(RESULT_SECS - 1);
    localparam logic [6:0]       DUR_MAX     = 7'(MAX_SECS);

    typedef enum logic [2:0] {
        S_IDLE_1P,
        S_IDLE_2P,
        S_FIGHT,
        S_PLAYING,
        S_P1_WIN,
        S_P2_WIN,
        S_EQ
    } state_t;

    state_t           state_q, state_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [6:0]       dur_q, dur_d;
    logic             two_q, two_d;
    logic [2:0]       hex_q, hex_d;
    logic             active_q, active_d;
    logic             sec_tick;

    // Display code for each state; code 6 is never produced.
    function automatic logic [2:0] hex_code(input state_t s);
        logic [2:0] code;
        case (s)
            S_IDLE_1P: code = 3'd0;
            S_IDLE_2P: code = 3'd1;
            S_FIGHT:   code = 3'd2;
            S_PLAYING: code = 3'd7;
            S_P1_WIN:  code = 3'd3;
            S_P2_WIN:  code = 3'd4;
            S_EQ:      code = 3'd5;
            default:   code = 3'd0;
        endcase
        return code;
    endfunction

    assign sec_tick = (psc_q == PSC_LAST);

    always_comb begin
        state_d = state_q;
        psc_d   = sec_tick ? '0 : psc_q + 1'b1;
        sec_d   = sec_q;
        dur_d   = dur_q;
        two_d   = two_q;

        case (state_q)
            S_IDLE_1P, S_IDLE_2P: begin
                // start beats a simultaneous toggle and latches the
                // pre-toggle mode.
                if (start) begin
                    state_d = S_FIGHT;
                    two_d   = (state_q == S_IDLE_2P);
                    dur_d   = '0;
                end else if (mode_toggle) begin
                    state_d = (state_q == S_IDLE_1P) ? S_IDLE_2P : S_IDLE_1P;
                end
            end

            S_FIGHT: begin
                if (sec_tick) begin
                    if (sec_q == FIGHT_LAST) begin
                        state_d = S_PLAYING;
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                end
            end

            S_PLAYING: begin
                // The duration still advances on a tick that coincides with a
                // death, so the frozen result shows the true elapsed time.
                if (sec_tick && (dur_q != DUR_MAX)) begin
                    dur_d = dur_q + 1'b1;
                end
                if (p1_dead && p2_dead) begin
                    state_d = S_EQ;
                end else if (p2_dead) begin
                    state_d = S_P1_WIN;
                end else if (p1_dead) begin
                    state_d = S_P2_WIN;
                end else if (dur_q == DUR_MAX) begin
                    state_d = S_EQ;
                end
            end

            S_P1_WIN, S_P2_WIN, S_EQ: begin
                // A start here only leaves the result; it never starts a new
                // match because idle is entered first.
                if (start || (sec_tick && (sec_q == RESULT_LAST))) begin
                    state_d = two_q ? S_IDLE_2P : S_IDLE_1P;
                end else if (sec_tick) begin
                    sec_d = sec_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE_1P;
            end
        endcase

        // Every transition restarts the time base so the new state gets whole
        // seconds from its first cycle.
        if (state_d != state_q) begin
            psc_d = '0;
            sec_d = '0;
        end

        hex_d    = hex_code(state_d);
        active_d = (state_d == S_PLAYING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE_1P;
            psc_q    <= '0;
            sec_q    <= '0;
            dur_q    <= '0;
            two_q    <= 1'b0;
            hex_q    <= 3'd0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            psc_q    <= psc_d;
            sec_q    <= sec_d;
            dur_q    <= dur_d;
            two_q    <= two_d;
            hex_q    <= hex_d;
            active_q <= active_d;
        end
    end

    assign hex_state     = hex_q;
    assign game_duration = dur_q;
    assign game_active   = active_q;
    assign two_player    = two_q;

endmodule

// File: doc/hex_state_sequencer.md
HEX_STATE_SEQUENCER -- requirements
Module: hex_state_sequencer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_SEC, default 50_000_000, meaning clock cycles per game second.
REQ-002 The block SHALL have parameter FIGHT_SECS, default 2, meaning seconds the FIGHt banner is shown.
REQ-003 The block SHALL have parameter RESULT_SECS, default 5, meaning seconds a result is held before returning to idle.
REQ-004 The block SHALL have parameter MAX_SECS, default 99, meaning the match time limit in seconds (1..99).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port mode_toggle, input, 1 bit: single-cycle pulse that flips between 1P and 2P while idle.
REQ-008 The block SHALL have port start, input, 1 bit: single-cycle pulse that starts a match, or skips the result hold.
REQ-009 The block SHALL have ports p1_dead and p2_dead, inputs, 1 bit each: level signals, player health exhausted.
REQ-010 The block SHALL have port hex_state, output, 3 bits: display code (0=1P, 1=2P, 2=FIGHt, 3=P1 win, 4=P2 win, 5=Eq, 7=live timer).
REQ-011 The block SHALL have port game_duration, output, 7 bits: elapsed match seconds, 0..MAX_SECS.
REQ-012 The block SHALL have port game_active, output, 1 bit: high only in PLAYING.
REQ-013 The block SHALL have port two_player, output, 1 bit: the mode latched at the last start.

Function
REQ-014 The block SHALL implement the states IDLE_1P, IDLE_2P, FIGHT, PLAYING, P1_WIN, P2_WIN and EQ.
REQ-015 hex_state, game_active and two_player SHALL be registered: hex_state is 0, 1, 2, 7, 3, 4, 5 respectively in those states, with code 6 never driven.
REQ-016 A free-running prescaler SHALL count 0..CLKS_PER_SEC-1, assert an internal sec_tick when at CLKS_PER_SEC-1, then wrap to 0.
REQ-017 The prescaler and the internal seconds counter SHALL clear to 0 on every state transition, so every timed state lasts exactly N*CLKS_PER_SEC cycles.
REQ-018 In IDLE_1P or IDLE_2P, mode_toggle SHALL switch to the other idle state on the next cycle.
REQ-019 In idle, start SHALL move to FIGHT, latch two_player (1 if leaving IDLE_2P) and clear game_duration to 0.
REQ-020 If start and mode_toggle arrive in the same cycle, start SHALL win and the pre-toggle mode SHALL be latched.
REQ-021 FIGHT SHALL last FIGHT_SECS seconds, then go to PLAYING; p*_dead, start and mode_toggle SHALL be ignored in FIGHT.
REQ-022 In PLAYING, each sec_tick SHALL increment game_duration, saturating at MAX_SECS.
REQ-023 In PLAYING, the exit priority SHALL be: p1_dead and p2_dead -> EQ; p2_dead only -> P1_WIN; p1_dead only -> P2_WIN; game_duration == MAX_SECS -> EQ.
REQ-024 A death in the same cycle as the tick that would reach MAX_SECS SHALL take the death outcome, and game_duration SHALL still take the incremented value.
REQ-025 In P1_WIN, P2_WIN and EQ, game_duration SHALL be frozen.
REQ-026 The result states SHALL exit after RESULT_SECS seconds, or on start (next cycle), to IDLE_2P if two_player is 1, else IDLE_1P.
REQ-027 A start that ends a result hold SHALL NOT also begin a match.
REQ-028 mode_toggle SHALL be ignored outside idle.

Reset
REQ-029 While rst is 1 at a clock edge, the block SHALL go to IDLE_1P with hex_state=0, game_duration=0, game_active=0, two_player=0, prescaler=0 and seconds counter=0.
REQ-030 rst SHALL take priority over every other input.
REQ-031 rst SHALL abort any state, including mid-match, with no residual count.

Verification (use CLKS_PER_SEC=4, FIGHT_SECS=2, RESULT_SECS=3, MAX_SECS=5)
REQ-032 Reset, then mode_toggle -> hex_state 0 then 1; start -> hex_state=2 for exactly 8 cycles, then 7, game_active=1, two_player=1.
REQ-033 In PLAYING, hold p2_dead=1 after 3 ticks -> hex_state=3, game_duration=3 frozen for 12 cycles, then hex_state=1.
REQ-034 No deaths -> game_duration steps 1..5 every 4 cycles, then hex_state=5 with game_duration=5 on the next cycle.
REQ-035 Assert p1_dead and p2_dead in the same cycle -> hex_state=5; p1_dead alone -> hex_state=4.
REQ-036 rst pulsed mid-PLAYING at game_duration=2 -> next cycle hex_state=0 and game_duration=0; start in the same cycle as rst is ignored.
REQ-037 In P1_WIN, a start pulse -> idle on the next cycle with hex_state equal to the latched mode, not 2.
